// File: rtl/icache_fetch_responder.sv
// -----------------------------------------------------------------------------
// icache_fetch_responder
//
// Direct-mapped instruction cache on the responder side of the fetch
// interface. The PC presents imemaddr/imemREN; a hit is answered
// combinationally in the same cycle (ihit doubles as the PC enable). A miss
// issues a single-word read to the memory controller, fills the frame when
// the read completes, spends one FILL cycle, and then the live request is
// looked up again in IDLE and hits if the address is unchanged.
//
// Frames: 2**IDX_BITS frames, each holding a valid bit, a tag and one word.
// Address split: [1:0] ignored, index = [IDX_BITS+1:2], tag = the rest.
//
// Ports:
//   CLK        in   system clock, rising edge
//   nRST       in   asynchronous active-low reset
//   imemREN    in   fetch request, held until ihit
//   imemaddr   in   fetch address (PC)
//   ihit       out  instruction valid this cycle
//   imemload   out  instruction word (0 when ihit is low)
//   iREN       out  read request to memory controller
//   iaddr      out  word-aligned memory read address (0 when iREN is low)
//   iwait      in   memory busy; low means iload is valid this cycle
//   iload      in   memory read data
//
// Optional build macro ICACHE_STATS_EN adds:
//   hit_count  out  cycles with ihit=1 (wraps)
//   miss_count out  IDLE->MISS transitions (wraps)
// -----------------------------------------------------------------------------
module icache_fetch_responder #(
  parameter int IDX_BITS = 4,
  parameter int ADDR_W   = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [ADDR_W-1:0] imemaddr,
  output logic              ihit,
  output logic [ADDR_W-1:0] imemload,
  output logic              iREN,
  output logic [ADDR_W-1:0] iaddr,
  input  logic              iwait,
  input  logic [ADDR_W-1:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int FRAMES = 1 << IDX_BITS;
  localparam int TAG_W  = ADDR_W - IDX_BITS - 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MISS = 2'd1,
    FILL = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Frame storage.
  logic [FRAMES-1:0] valid_q;
  logic [TAG_W-1:0]  tag_q  [FRAMES];
  logic [ADDR_W-1:0] data_q [FRAMES];

  // Word address of the outstanding miss; the byte offset is always zero.
  logic [ADDR_W-3:0] miss_word_q;

  logic [IDX_BITS-1:0] req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic [IDX_BITS-1:0] fill_idx;
  logic [TAG_W-1:0]    fill_tag;
  logic                lookup_hit;
  logic                start_miss;
  logic                fill_en;

  // Byte offset of the fetch address plays no part in lookup or refill.
  logic unused_addr_bits;
  assign unused_addr_bits = ^imemaddr[1:0];

  assign req_idx  = imemaddr[IDX_BITS+1:2];
  assign req_tag  = imemaddr[ADDR_W-1:IDX_BITS+2];
  assign fill_idx = miss_word_q[IDX_BITS-1:0];
  assign fill_tag = miss_word_q[ADDR_W-3:IDX_BITS];

  assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // ---------------------------------------------------------------------------
  // Next-state and outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    ihit       = 1'b0;
    imemload   = '0;
    iREN       = 1'b0;
    iaddr      = '0;
    start_miss = 1'b0;
    fill_en    = 1'b0;

    case (state_q)
      IDLE: begin
        if (imemREN) begin
          if (lookup_hit) begin
            ihit     = 1'b1;
            imemload = data_q[req_idx];
          end else begin
            start_miss = 1'b1;
            state_d    = MISS;
          end
        end
      end

      MISS: begin
        // Address comes from the latched miss, so a PC redirect while the
        // read is outstanding cannot disturb the memory transaction.
        iREN  = 1'b1;
        iaddr = {miss_word_q, 2'b00};
        if (!iwait) begin
          fill_en = 1'b1;
          state_d = FILL;
        end
      end

      FILL: begin
        // Bubble cycle: the new frame becomes visible to the IDLE lookup.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values present before the clock edge.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      miss_word_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_miss) begin
        miss_word_q <= imemaddr[ADDR_W-1:2];
      end
      if (fill_en) begin
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  // NOTE: tag and data arrays carry no reset; the cleared valid bits already
  // make their contents unobservable, and leaving them unreset lets them map
  // onto plain storage.
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  // ---------------------------------------------------------------------------
  // Statistics counters, free-running and wrapping.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (ihit) begin
        hit_count <= hit_count + 32'd1;
      end
      if (start_miss) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_fetch_responder.sv
// -----------------------------------------------------------------------------
// Directed bench for icache_fetch_responder. Inputs change 1 time unit after
// the rising edge; outputs are compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_icache_fetch_responder;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  int unsigned exp_hits;
  int unsigned exp_misses;
`endif

  int checks;
  int errors;

  icache_fetch_responder #(
    .IDX_BITS(4),
    .ADDR_W  (32)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .imemREN   (imemREN),
    .imemaddr  (imemaddr),
    .ihit      (ihit),
    .imemload  (imemload),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .iwait     (iwait),
    .iload     (iload)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

`ifdef ICACHE_STATS_EN
  task automatic check_stats(input string tag);
    check({tag, "_hit_count"}, hit_count, exp_hits);
    check({tag, "_miss_count"}, miss_count, exp_misses);
  endtask
`endif

  // Full miss sequence: IDLE miss, 'waits' busy cycles, completion, FILL,
  // then the replayed request hits.
  task automatic fetch_miss(input string tag, input logic [31:0] addr,
                            input logic [31:0] data, input int waits);
    logic [31:0] exp_iaddr;
    exp_iaddr = addr & 32'hFFFF_FFFC;
    imemREN  = 1'b1;
    imemaddr = addr;
    iwait    = 1'b1;
    sample();
    check({tag, "_idle_ihit"}, ihit, 1'b0);
    check({tag, "_idle_iren"}, iREN, 1'b0);
    tick();
`ifdef ICACHE_STATS_EN
    exp_misses++;
`endif
    for (int i = 0; i < waits; i++) begin
      iwait = 1'b1;
      sample();
      check({tag, "_busy_iren"}, iREN, 1'b1);
      check({tag, "_busy_iaddr"}, iaddr, exp_iaddr);
      check({tag, "_busy_ihit"}, ihit, 1'b0);
      tick();
    end
    iwait = 1'b0;
    iload = data;
    sample();
    check({tag, "_done_iren"}, iREN, 1'b1);
    check({tag, "_done_iaddr"}, iaddr, exp_iaddr);
    tick();
    iwait = 1'b1;
    iload = 32'hDEAD_BEEF;
    sample();
    check({tag, "_fill_iren"}, iREN, 1'b0);
    check({tag, "_fill_ihit"}, ihit, 1'b0);
    tick();
    sample();
    check({tag, "_replay_ihit"}, ihit, 1'b1);
    check({tag, "_replay_data"}, imemload, data);
    check({tag, "_replay_iren"}, iREN, 1'b0);
    tick();
`ifdef ICACHE_STATS_EN
    exp_hits++;
`endif
  endtask

  task automatic fetch_hit(input string tag, input logic [31:0] addr, input logic [31:0] data);
    imemREN  = 1'b1;
    imemaddr = addr;
    iwait    = 1'b1;
    sample();
    check({tag, "_ihit"}, ihit, 1'b1);
    check({tag, "_data"}, imemload, data);
    check({tag, "_iren"}, iREN, 1'b0);
    tick();
`ifdef ICACHE_STATS_EN
    exp_hits++;
`endif
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    nRST     = 1'b0;
    imemREN  = 1'b0;
    imemaddr = '0;
    iwait    = 1'b1;
    iload    = '0;
`ifdef ICACHE_STATS_EN
    exp_hits   = 0;
    exp_misses = 0;
`endif

    // Reset state.
    sample();
    check("rst_ihit", ihit, 1'b0);
    check("rst_imemload", imemload, 32'h0);
    check("rst_iren", iREN, 1'b0);
    check("rst_iaddr", iaddr, 32'h0);
    tick();
    nRST = 1'b1;

    // No request: nothing returned.
    sample();
    check("noreq_ihit", ihit, 1'b0);
    check("noreq_imemload", imemload, 32'h0);
    tick();

    // Cold miss with three busy cycles: iREN high for exactly four cycles.
    fetch_miss("cold", 32'h0000_0040, 32'h8C01_0004, 3);
`ifdef ICACHE_STATS_EN
    check_stats("cold");
`endif

    // Warm hits and low-bit alias.
    fetch_hit("warm0", 32'h0000_0040, 32'h8C01_0004);
    fetch_hit("warm1", 32'h0000_0040, 32'h8C01_0004);
    fetch_hit("alias", 32'h0000_0043, 32'h8C01_0004);
`ifdef ICACHE_STATS_EN
    check_stats("warm");
`endif

    // Unaligned miss: iaddr must carry zero low bits.
    fetch_miss("unaligned", 32'h0000_0047, 32'h2222_0044, 1);
    fetch_hit("unaligned_hit", 32'h0000_0044, 32'h2222_0044);

    // Index conflict: 0x80 evicts 0x40, which then misses again.
    fetch_miss("conflict80", 32'h0000_0080, 32'h1111_0080, 0);
    fetch_miss("conflict40", 32'h0000_0040, 32'h8C01_0004, 2);

    // Redirect mid-miss: read for 0x100 continues while PC moves to 0x200.
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0100;
    sample();
    check("redir_idle_ihit", ihit, 1'b0);
    tick();
`ifdef ICACHE_STATS_EN
    exp_misses++;
`endif
    sample();
    check("redir_m1_iaddr", iaddr, 32'h0000_0100);
    tick();
    imemaddr = 32'h0000_0200;
    sample();
    check("redir_m2_iaddr", iaddr, 32'h0000_0100);
    check("redir_m2_ihit", ihit, 1'b0);
    tick();
    iwait = 1'b0;
    iload = 32'hAAAA_0100;
    sample();
    check("redir_m3_iaddr", iaddr, 32'h0000_0100);
    check("redir_m3_iren", iREN, 1'b1);
    tick();
    iwait    = 1'b1;
    iload    = 32'hDEAD_BEEF;
    imemaddr = 32'h0000_0100;
    sample();
    check("redir_fill_ihit", ihit, 1'b0);
    tick();
    // Frame 0 now holds 0x100.
    sample();
    check("redir_probe_ihit", ihit, 1'b1);
    check("redir_probe_data", imemload, 32'hAAAA_0100);
    tick();
`ifdef ICACHE_STATS_EN
    exp_hits++;
`endif
    fetch_miss("redir200", 32'h0000_0200, 32'hBBBB_0200, 2);

    // imemREN dropped during the miss: fill completes, no hit produced.
    imemREN  = 1'b1;
    imemaddr = 32'h0000_000C;
    sample();
    check("drop_idle_ihit", ihit, 1'b0);
    tick();
`ifdef ICACHE_STATS_EN
    exp_misses++;
`endif
    imemREN = 1'b0;
    sample();
    check("drop_m1_iren", iREN, 1'b1);
    check("drop_m1_iaddr", iaddr, 32'h0000_000C);
    tick();
    iwait = 1'b0;
    iload = 32'hCCCC_000C;
    sample();
    check("drop_m2_iren", iREN, 1'b1);
    tick();
    iwait = 1'b1;
    sample();
    check("drop_fill_ihit", ihit, 1'b0);
    tick();
    sample();
    check("drop_idle2_ihit", ihit, 1'b0);
    check("drop_idle2_imemload", imemload, 32'h0);
    tick();
    fetch_hit("drop_refetch", 32'h0000_000C, 32'hCCCC_000C);
`ifdef ICACHE_STATS_EN
    check_stats("pre_reset");
`endif

    // Reset mid-miss: iREN must drop without waiting for a clock edge.
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0008;
    sample();
    check("rstmiss_idle_ihit", ihit, 1'b0);
    tick();
    sample();
    check("rstmiss_iren_before", iREN, 1'b1);
    #2;
    nRST = 1'b0;
    #1;
    check("rstmiss_iren_async", iREN, 1'b0);
    check("rstmiss_ihit_async", ihit, 1'b0);
    check("rstmiss_iaddr_async", iaddr, 32'h0);
    tick();
    nRST = 1'b1;
`ifdef ICACHE_STATS_EN
    exp_hits   = 0;
    exp_misses = 0;
    check_stats("post_reset");
`endif

    // Previously filled address must miss after reset.
    fetch_miss("post_rst40", 32'h0000_0040, 32'h8C01_0004, 1);
`ifdef ICACHE_STATS_EN
    check_stats("final");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_fetch_responder.md
Name: icache_fetch_responder

Overview:
- Direct-mapped instruction cache that answers the program counter's fetch requests. It is the responder side of the fetch interface: PC drives the address and read enable, and this block returns the instruction plus a hit strobe. The datapath uses that hit strobe as the PC enable.
- On a miss it issues a single-word read to the memory controller, waits for completion, fills the frame, then replays the request as a hit.

Parameters:
- IDX_BITS, 4, log2 of frame count (16 frames of one 32-bit word each).
- ADDR_W, 32, address and data width.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- imemREN  input  1  fetch request from datapath, level-held until ihit.
- imemaddr  input  ADDR_W  fetch address (current PC).
- ihit  output  1  instruction valid this cycle; datapath uses it as pcen.
- imemload  output  ADDR_W  instruction returned to datapath.
- iREN  output  1  read request to memory controller.
- iaddr  output  ADDR_W  memory read address.
- iwait  input  1  memory busy; 0 means iload is valid this cycle.
- iload  input  ADDR_W  memory read data.

Behaviour:
- Address split: bits [1:0] are ignored (word aligned). index = imemaddr[IDX_BITS+1:2]. tag = imemaddr[ADDR_W-1:IDX_BITS+2].
- Each frame holds a valid bit, a tag, and a data word.
- Reset (asynchronous, nRST=0):
  - all valid bits cleared; tag and data arrays may be left uncleared;
  - state goes to IDLE;
  - ihit=0, imemload=0, iREN=0, iaddr=0.
- FSM has three states: IDLE, MISS, FILL.
- IDLE:
  - Hit when imemREN=1 and the frame is valid with a matching tag. ihit=1 combinationally in the same cycle and imemload = frame data. Zero-cycle hit latency; stay in IDLE.
  - Miss when imemREN=1 and the frame is invalid or the tag mismatches. ihit=0. Latch miss_addr = {imemaddr[ADDR_W-1:2],2'b00} and go to MISS.
  - imemREN=0: ihit=0, imemload=0, stay in IDLE.
- MISS:
  - iREN=1 and iaddr=miss_addr, held stable every cycle while iwait=1.
  - When iwait=0: capture iload into the frame indexed by miss_addr, set its tag and valid=1, and go to FILL.
  - ihit=0 throughout MISS.
- FILL: single cycle with iREN=0 and ihit=0. Go to IDLE, where the request is re-evaluated against the live imemaddr.
- Miss latency: ihit rises 2 cycles after the cycle in which iwait=0 is seen, provided the address is unchanged.
- imemaddr changing during MISS (branch redirect): the outstanding read keeps miss_addr and the fill completes into miss_addr's frame. The new address is evaluated only on return to IDLE.
- imemREN dropping during MISS: the fill still completes and no ihit is produced.
- Index conflict: a fill replaces the previous frame contents unconditionally.
- Reset during MISS: iREN drops immediately (asynchronously) and the memory transaction is abandoned. After reset deasserts, the first fetch misses.
- Not supported: no write path, no invalidate port, no halt flush. Instruction memory is read-only.

Optional Feature:
- Macro ICACHE_STATS_EN.
- Defined: adds output ports hit_count[31:0] and miss_count[31:0].
  - hit_count increments on each cycle with ihit=1.
  - miss_count increments on each IDLE→MISS transition.
  - Both reset to 0 and wrap at 2^32−1 → 0.
- Undefined: these ports and counters are absent; functional behaviour is otherwise identical.

Test Plan:
- Cold miss: reset, then imemREN=1 with imemaddr=0x00000040, memory returns iload=0x8C010004 after 3 iwait cycles.
  - Required: iREN=1 and iaddr=0x40 for exactly 4 cycles, one FILL cycle, then ihit=1 with imemload=0x8C010004.
  - With ICACHE_STATS_EN: miss_count=1.
- Warm hit: re-fetch 0x40 → ihit=1 in the same cycle, iREN stays 0. With ICACHE_STATS_EN: hit_count increments by 1 per hit cycle.
- Conflict: fill 0x40, then fetch 0x80 (same index 0, different tag) → miss and refill. A subsequent fetch of 0x40 misses again.
- Redirect mid-miss: during MISS for 0x100, change imemaddr to 0x200.
  - Required: iaddr stays 0x100 and frame 0 holds tag 0x100 afterwards.
  - Then a miss is issued for 0x200 and ihit is asserted only with 0x200's data.
- Reset mid-miss: assert nRST=0 while iREN=1.
  - Required: iREN=0 and ihit=0 immediately.
  - After release, a fetch of a previously filled address misses (valid bits cleared).
- Low-bit alias: fetch 0x43 after 0x40 is cached → ihit=1 returning 0x40's data; iaddr is never driven with nonzero [1:0].
